// File: rtl/nibbler_fetch.sv
// Nibbler CPU fetch/PC stage: drives the program ROM, latches opcode/operand, alternates fetch and execute phases.
// Two enabled cycles per instruction; run=0 freezes every register, including the ROM strobes.
module nibbler_fetch #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   romData,
  output logic [ADDR_W-1:0]   romAddress,
  output logic                romNotChipEnable,
  output logic                romNotOutputEnable,
  output logic                romNotWriteEnable,
  input  logic                run,
  input  logic                incPC,
  input  logic                notLoadPC,
  output logic [DATA_W/2-1:0] instruction,
  output logic [DATA_W/2-1:0] operand,
  output logic                ph,
  output logic [ADDR_W-1:0]   pc
);

  localparam int NIB = DATA_W / 2;

  typedef enum logic [1:0] {WAKE, FETCH, EXEC} state_t;

  state_t          state, state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [NIB-1:0]  instruction_nx, operand_nx;
  logic            ph_nx, ce_n_nx, oe_n_nx;

  assign romAddress        = pc;
  assign romNotWriteEnable = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= WAKE;
      pc                 <= '0;
      instruction        <= '0;
      operand            <= '0;
      ph                 <= 1'b0;
      romNotChipEnable   <= 1'b1;
      romNotOutputEnable <= 1'b1;
    end else begin
      state              <= state_nx;
      pc                 <= pc_nx;
      instruction        <= instruction_nx;
      operand            <= operand_nx;
      ph                 <= ph_nx;
      romNotChipEnable   <= ce_n_nx;
      romNotOutputEnable <= oe_n_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    instruction_nx = instruction;
    operand_nx     = operand;
    ph_nx          = ph;
    ce_n_nx        = romNotChipEnable;
    oe_n_nx        = romNotOutputEnable;
    if (run) begin
      case (state)
        WAKE: begin
          state_nx = FETCH;
          ce_n_nx  = 1'b0;
          oe_n_nx  = 1'b0;
        end
        FETCH: begin
          instruction_nx = romData[DATA_W-1:NIB];
          operand_nx     = romData[NIB-1:0];
          pc_nx          = pc + ADDR_W'(1);
          ph_nx          = 1'b1;
          state_nx       = EXEC;
        end
        EXEC: begin
          // A jump target takes priority over skipping the immediate byte.
          if (!notLoadPC)
            pc_nx = ADDR_W'({operand, romData});
          else if (incPC)
            pc_nx = pc + ADDR_W'(1);
          ph_nx    = 1'b0;
          state_nx = FETCH;
        end
        default: state_nx = WAKE;
      endcase
    end
  end

endmodule

// File: doc/nibbler_fetch.md
# nibbler_fetch

Instruction fetch and program-counter stage of the Nibbler CPU. It sits upstream of the program ROM and the microrom. It drives the 12-bit ROM address and the active-low ROM strobes, and latches each fetched byte into a 4-bit instruction and a 4-bit operand. It generates the `ph` phase bit consumed by the microrom, and applies the microrom's `incPC` / `notLoadPC` controls to sequence, skip and jump.

## Interface
Parameters:
- `ADDR_W`, 12, ROM address / program counter width
- `DATA_W`, 8, ROM data width; upper nibble is the opcode, lower nibble is the operand

Ports:
- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-high reset
- `romData`  in  8  byte read from the ROM `io` bus, combinational from `romAddress`
- `romAddress`  out  12  ROM address; always equal to `pc`
- `romNotChipEnable`  out  1  ROM chip enable, active low
- `romNotOutputEnable`  out  1  ROM output enable, active low
- `romNotWriteEnable`  out  1  ROM write enable; constant 1, so the ROM is never written
- `run`  in  1  1 = advance the FSM; 0 = freeze all state
- `incPC`  in  1  from the microrom; in the execute phase, skip the next byte (immediate or address byte)
- `notLoadPC`  in  1  from the microrom, active low; in the execute phase, jump to `{operand, romData}`
- `instruction`  out  4  latched opcode (`romData[7:4]`)
- `operand`  out  4  latched operand (`romData[3:0]`)
- `ph`  out  1  phase to the microrom: 0 = fetch, 1 = execute
- `pc`  out  12  current program counter

## Operation
The block is a three-state FSM: `WAKE`, `FETCH`, `EXEC`. All registers are updated on the rising edge of `clk`, and only when `run`=1 (except `reset`).

- **Reset** (asynchronous, in any state, including mid-EXEC), all registers clear immediately:
  - state = `WAKE`, `pc` = 0x000, `instruction` = 0, `operand` = 0, `ph` = 0
  - `romNotChipEnable` = 1, `romNotOutputEnable` = 1, `romNotWriteEnable` = 1
- **WAKE**: the ROM is disabled. On the first enabled edge the state moves to `FETCH`, and `romNotChipEnable` / `romNotOutputEnable` go to 0. `pc` is unchanged.
- **FETCH** (`ph`=0): `romAddress` = `pc`. On an enabled edge:
  - `{instruction, operand}` <= `romData`
  - `pc` <= `pc` + 1
  - `ph` <= 1
  - state <= `EXEC`
- **EXEC** (`ph`=1): `romAddress` = `pc`, which addresses the byte following the opcode. On an enabled edge, the PC update has this priority:
  - if `notLoadPC`=0: `pc` <= `{operand, romData}`
  - else if `incPC`=1: `pc` <= `pc` + 1
  - else: `pc` is held
  - In all three cases `ph` <= 0 and state <= `FETCH`. `instruction` and `operand` hold.
- When `notLoadPC`=0 and `incPC`=1 arrive together, the load wins.
- PC arithmetic is modulo 2^12: 0xFFF + 1 wraps to 0x000, with no flag.
- When `run`=0:
  - every register holds, including the state
  - the ROM strobes keep their registered values
  - `incPC` and `notLoadPC` are ignored
- The ROM strobes are registered outputs and never toggle between `FETCH` and `EXEC`.
- `incPC` and `notLoadPC` are sampled only in `EXEC`. In `FETCH` and `WAKE` they are ignored.

## Timing
- All outputs are registered. `romAddress` is the `pc` register directly.
- `romData` must settle within the same cycle as the `romAddress` that produced it.
- Reset to first instruction latched: 2 enabled edges (`WAKE`→`FETCH`, then `FETCH`→`EXEC`).
- Each instruction takes exactly 2 enabled cycles, independent of its type.
- `instruction`, `operand` and `ph`=1 become visible to the microrom in the cycle after the fetch edge. The microrom's control response must be valid before the following edge.
- After a jump edge, the next cycle is `FETCH` at the new target.
- Reset asserted between edges aborts the instruction and clears state immediately. Deassertion takes effect at the next edge (`WAKE`).

## Test plan
- **Reset / wake**:
  - Stimulus: assert `reset`, then release with `run`=1.
  - Response: `pc`=0x000, `ph`=0, strobes = 1/1/1. After 1 edge, strobes = 0/0/1 and `pc` is still 0x000.
- **Sequential fetch**:
  - Stimulus: ROM[0]=0x35, ROM[1]=0x72, `incPC`=0, `notLoadPC`=1.
  - Response: after the fetch edge, `instruction`=3, `operand`=5, `ph`=1, `pc`=0x001. After exec, `pc`=0x001 and `ph`=0. The next fetch yields `instruction`=7, `operand`=2.
- **Skip immediate**:
  - Stimulus: ROM[0]=0x10, `incPC`=1 in EXEC.
  - Response: `pc` goes 0x000→0x001→0x002.
- **Jump**:
  - Stimulus: ROM[4]=0xAB, ROM[5]=0xCD, `notLoadPC`=0 and `incPC`=1 in EXEC.
  - Response: `pc`=0xBCD (load beats increment), and the next FETCH addresses 0xBCD.
- **Wrap / stall**:
  - Stimulus: `pc`=0xFFF in FETCH. Then hold `run`=0 for 3 cycles in EXEC.
  - Response: after the fetch edge `pc`=0x000. All outputs stay frozen during the stall. Execute completes on the first edge with `run`=1.
- **Reset mid-operation**:
  - Stimulus: assert `reset` asynchronously during EXEC with `pc`=0x123.
  - Response: `pc`=0x000, `ph`=0, `instruction`=0 and strobes=1 immediately, without waiting for a clock edge.
